// File: rtl/vga_pixel_fetch.sv
// Frame-buffer read stage: maps VGA counters to a BRAM line address in the displayed
// bank, realigns sync/blank with the read data and expands RGB444 to RGB888.
module vga_pixel_fetch #(
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned BANK_SIZE  = 76800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blank,
  input  logic        swap_req,
  output logic        swap_ack,
  output logic        rd_bank,
  output logic [17:0] bram_addr,
  input  logic [11:0] bram_dout,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_blank
);

  localparam int unsigned DEPTH     = RD_LATENCY + 1;
  localparam logic [17:0] BANK1_BASE = 18'(BANK_SIZE);

  typedef enum logic {BANK_0 = 1'b0, BANK_1 = 1'b1} bank_e;

  bank_e             bank_q, bank_d;
  logic              prev_vsync_q, prev_vsync_d;
  logic              swap_ack_q, swap_ack_d;
  logic              frame_edge;

  logic              in_range;
  logic [8:0]        row, col;
  logic [17:0]       pix_off, bank_base;
  logic [17:0]       bram_addr_q, bram_addr_d;

  logic [DEPTH-1:0]  hs_pipe_q, hs_pipe_d;
  logic [DEPTH-1:0]  vs_pipe_q, vs_pipe_d;
  logic [DEPTH-1:0]  fb_pipe_q, fb_pipe_d;

  logic [7:0]        vga_r_q, vga_r_d, vga_g_q, vga_g_d, vga_b_q, vga_b_d;
  logic              vga_hsync_q, vga_hsync_d;
  logic              vga_vsync_q, vga_vsync_d;
  logic              vga_blank_q, vga_blank_d;

  always_comb begin
    prev_vsync_d = vsync;
    frame_edge   = prev_vsync_q & ~vsync;
    bank_d       = bank_q;
    swap_ack_d   = 1'b0;
    if (frame_edge && swap_req) begin
      bank_d     = (bank_q == BANK_0) ? BANK_1 : BANK_0;
      swap_ack_d = 1'b1;
    end
  end

  // Address is built from the next bank so a committed swap reaches bram_addr
  // on the cycle right after the vsync edge.
  always_comb begin
    in_range    = (hcount < 10'd640) && (vcount < 10'd480);
    row         = vcount[9:1];
    col         = hcount[9:1];
    pix_off     = ({9'd0, row} << 8) + ({9'd0, row} << 6) + {9'd0, col};
    bank_base   = (bank_d == BANK_1) ? BANK1_BASE : '0;
    bram_addr_d = in_range ? (bank_base + pix_off) : bank_base;
  end

  always_comb begin
    hs_pipe_d   = {hs_pipe_q[DEPTH-2:0], hsync};
    vs_pipe_d   = {vs_pipe_q[DEPTH-2:0], vsync};
    fb_pipe_d   = {fb_pipe_q[DEPTH-2:0], ~in_range | blank};
    vga_hsync_d = hs_pipe_q[DEPTH-1];
    vga_vsync_d = vs_pipe_q[DEPTH-1];
    vga_blank_d = fb_pipe_q[DEPTH-1];
    vga_r_d     = '0;
    vga_g_d     = '0;
    vga_b_d     = '0;
    if (!fb_pipe_q[DEPTH-1]) begin
      vga_r_d = {bram_dout[11:8], bram_dout[11:8]};
      vga_g_d = {bram_dout[7:4],  bram_dout[7:4]};
      vga_b_d = {bram_dout[3:0],  bram_dout[3:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q       <= BANK_0;
      prev_vsync_q <= 1'b1;
      swap_ack_q   <= 1'b0;
      bram_addr_q  <= '0;
      hs_pipe_q    <= '1;
      vs_pipe_q    <= '1;
      fb_pipe_q    <= '1;
      vga_r_q      <= '0;
      vga_g_q      <= '0;
      vga_b_q      <= '0;
      vga_hsync_q  <= 1'b1;
      vga_vsync_q  <= 1'b1;
      vga_blank_q  <= 1'b1;
    end else begin
      bank_q       <= bank_d;
      prev_vsync_q <= prev_vsync_d;
      swap_ack_q   <= swap_ack_d;
      bram_addr_q  <= bram_addr_d;
      hs_pipe_q    <= hs_pipe_d;
      vs_pipe_q    <= vs_pipe_d;
      fb_pipe_q    <= fb_pipe_d;
      vga_r_q      <= vga_r_d;
      vga_g_q      <= vga_g_d;
      vga_b_q      <= vga_b_d;
      vga_hsync_q  <= vga_hsync_d;
      vga_vsync_q  <= vga_vsync_d;
      vga_blank_q  <= vga_blank_d;
    end
  end

  assign rd_bank   = bank_q;
  assign swap_ack  = swap_ack_q;
  assign bram_addr = bram_addr_q;
  assign vga_r     = vga_r_q;
  assign vga_g     = vga_g_q;
  assign vga_b     = vga_b_q;
  assign vga_hsync = vga_hsync_q;
  assign vga_vsync = vga_vsync_q;
  assign vga_blank = vga_blank_q;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Scoreboard bench for vga_pixel_fetch: directed pixels and bank swaps with
// hand-computed expectations, checked by a decoupled monitor at the falling edge.
module tb_vga_pixel_fetch;

  localparam int unsigned RDL = 2;
  localparam int unsigned LAT = RDL + 2;

  localparam int K_ADDR = 0, K_RGB = 1, K_SYNC = 2, K_BANK = 3, K_RST = 4, K_RFL = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  hcount, vcount;
  logic        hsync, vsync, blank, swap_req;
  logic        swap_ack, rd_bank;
  logic [17:0] bram_addr;
  logic [11:0] bram_dout;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hsync, vga_vsync, vga_blank;

  vga_pixel_fetch #(.RD_LATENCY(RDL), .BANK_SIZE(76800)) dut (
    .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount),
    .hsync(hsync), .vsync(vsync), .blank(blank), .swap_req(swap_req),
    .swap_ack(swap_ack), .rd_bank(rd_bank), .bram_addr(bram_addr),
    .bram_dout(bram_dout), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_blank(vga_blank)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame-buffer contents at the addresses the vectors touch; all else reads FFF.
  function automatic logic [11:0] mem(input logic [17:0] a);
    case (a)
      18'd641:   mem = 12'hA5C;
      18'd77441: mem = 12'h123;
      18'd76799: mem = 12'h9E7;
      default:   mem = 12'hFFF;
    endcase
  endfunction

  logic [11:0] rd_p1;
  always @(posedge clk) begin
    rd_p1     <= mem(bram_addr);
    bram_dout <= rd_p1;
  end

  typedef struct {
    int unsigned due;
    int          kind;
    logic [63:0] exp;
  } chk_t;

  chk_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic push(input int unsigned due, input int kind, input logic [63:0] e);
    chk_t c;
    c.due = due; c.kind = kind; c.exp = e;
    sb.push_back(c);
  endtask

  function automatic string kname(input int k);
    case (k)
      K_ADDR:  kname = "bram_addr";
      K_RGB:   kname = "rgb";
      K_SYNC:  kname = "hs_vs_blank";
      K_BANK:  kname = "bank_ack";
      K_RST:   kname = "reset_state";
      default: kname = "refill_blank";
    endcase
  endfunction

  function automatic logic [63:0] actual(input int k);
    case (k)
      K_ADDR:  actual = 64'(bram_addr);
      K_RGB:   actual = 64'({vga_r, vga_g, vga_b});
      K_SYNC:  actual = 64'({vga_hsync, vga_vsync, vga_blank});
      K_BANK:  actual = 64'({rd_bank, swap_ack});
      K_RST:   actual = 64'({bram_addr, rd_bank, swap_ack, vga_r, vga_g, vga_b,
                             vga_hsync, vga_vsync, vga_blank});
      default: actual = 64'({vga_r, vga_g, vga_b, vga_hsync, vga_vsync, vga_blank});
    endcase
  endfunction

  always @(negedge clk) begin
    logic [63:0] act;
    for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        act = actual(sb[i].kind);
        checks++;
        if (sb[i].due != cyc || act !== sb[i].exp) begin
          failures++;
          $display("FAIL %s cyc=%0d due=%0d got=%h exp=%h",
                   kname(sb[i].kind), cyc, sb[i].due, act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic idle();
    hcount = 10'd0; vcount = 10'd0; hsync = 1'b1; vsync = 1'b1;
    blank = 1'b1; swap_req = 1'b0;
  endtask

  task automatic drv(input logic [9:0] h, input logic [9:0] v, input logic hs,
                     input logic vs, input logic bl, input logic sr,
                     input logic [17:0] ea, input logic [23:0] ergb, input logic eb,
                     input logic ebank, input logic eack);
    @(posedge clk); #1;
    hcount = h; vcount = v; hsync = hs; vsync = vs; blank = bl; swap_req = sr;
    push(cyc + 1, K_ADDR, 64'(ea));
    push(cyc + 1, K_BANK, 64'({ebank, eack}));
    push(cyc + LAT, K_RGB, 64'(ergb));
    push(cyc + LAT, K_SYNC, 64'({hs, vs, eb}));
  endtask

  // Fixed pixel (3,5): address/colour depend only on the bank in effect.
  task automatic px(input logic vs, input logic sr, input logic ebank, input logic eack);
    drv(10'd3, 10'd5, 1'b1, vs, 1'b0, sr, ebank ? 18'd77441 : 18'd641,
        ebank ? 24'h112233 : 24'hAA55CC, 1'b0, ebank, eack);
  endtask

  localparam logic [63:0] RST_EXP = 64'({18'd0, 1'b0, 1'b0, 24'd0, 3'b111});

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 push(cyc, K_RST, RST_EXP);
    @(posedge clk); #1 rst_n = 1'b1;

    drv(10'd3,    10'd5,    1'b1, 1'b1, 1'b0, 1'b0, 18'd641,   24'hAA55CC, 1'b0, 1'b0, 1'b0);
    drv(10'd639,  10'd479,  1'b1, 1'b1, 1'b0, 1'b0, 18'd76799, 24'h99EE77, 1'b0, 1'b0, 1'b0);
    drv(10'd700,  10'd10,   1'b1, 1'b1, 1'b0, 1'b0, 18'd0,     24'h000000, 1'b1, 1'b0, 1'b0);
    drv(10'd3,    10'd5,    1'b1, 1'b1, 1'b1, 1'b0, 18'd641,   24'h000000, 1'b1, 1'b0, 1'b0);
    drv(10'd638,  10'd478,  1'b0, 1'b1, 1'b0, 1'b0, 18'd76799, 24'h99EE77, 1'b0, 1'b0, 1'b0);
    drv(10'd1023, 10'd1023, 1'b1, 1'b1, 1'b0, 1'b0, 18'd0,     24'h000000, 1'b1, 1'b0, 1'b0);
    drv(10'd0,    10'd0,    1'b1, 1'b1, 1'b0, 1'b0, 18'd0,     24'hFFFFFF, 1'b0, 1'b0, 1'b0);
    drv(10'd640,  10'd0,    1'b1, 1'b1, 1'b0, 1'b0, 18'd0,     24'h000000, 1'b1, 1'b0, 1'b0);
    drv(10'd0,    10'd480,  1'b1, 1'b1, 1'b0, 1'b0, 18'd0,     24'h000000, 1'b1, 1'b0, 1'b0);

    // Swap held across one edge, then an edge without request.
    px(1'b1, 1'b1, 1'b0, 1'b0);
    px(1'b0, 1'b1, 1'b1, 1'b1);
    px(1'b0, 1'b0, 1'b1, 1'b0);
    px(1'b1, 1'b0, 1'b1, 1'b0);
    px(1'b0, 1'b0, 1'b1, 1'b0);
    px(1'b1, 1'b0, 1'b1, 1'b0);
    // Request held across two edges toggles twice.
    px(1'b1, 1'b1, 1'b1, 1'b0);
    px(1'b0, 1'b1, 1'b0, 1'b1);
    px(1'b0, 1'b1, 1'b0, 1'b0);
    px(1'b1, 1'b1, 1'b0, 1'b0);
    px(1'b0, 1'b1, 1'b1, 1'b1);
    // Pulse between edges is ignored; request rising on the edge is honoured.
    px(1'b1, 1'b0, 1'b1, 1'b0);
    px(1'b1, 1'b1, 1'b1, 1'b0);
    px(1'b1, 1'b0, 1'b1, 1'b0);
    px(1'b0, 1'b0, 1'b1, 1'b0);
    px(1'b1, 1'b0, 1'b1, 1'b0);
    px(1'b0, 1'b1, 1'b0, 1'b1);
    px(1'b1, 1'b0, 1'b0, 1'b0);
    px(1'b0, 1'b1, 1'b1, 1'b1);
    px(1'b1, 1'b0, 1'b1, 1'b0);

    // Mid-stream reset drops in-flight pixels and returns to bank 0.
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    push(cyc, K_RST, RST_EXP);
    @(posedge clk); #1;
    push(cyc, K_RST, RST_EXP);
    rst_n = 1'b1;
    hcount = 10'd3; vcount = 10'd5; hsync = 1'b1; vsync = 1'b1; blank = 1'b0; swap_req = 1'b0;
    push(cyc + 1, K_ADDR, 64'(18'd641));
    push(cyc + 1, K_BANK, 64'(2'b00));
    for (int unsigned k = 1; k < LAT; k++) push(cyc + k, K_RFL, 64'({24'd0, 3'b111}));
    push(cyc + LAT, K_RGB, 64'(24'hAA55CC));
    push(cyc + LAT, K_SYNC, 64'(3'b110));

    @(posedge clk); #1 idle();
    repeat (LAT + 2) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL pending_checks got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d exp=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
